edge_task_queue: RTL and testbench

- Per-PE task buffer directly downstream of the packet/decoder/RS front end.
- Consumes the per-Edge-PE task packets and valids the RS dispatches, and holds up to DEPTH tasks per PE.
- Issues each task to its Edge PE with a valid/ready handshake, then tracks execution until the PE signals completion.
- Produces the PE_IDLE vector that the RS and decoder use for dispatch and completion decisions.

---
 rtl/edge_task_queue.sv | 135 +++++++++++++
 tb/tb_edge_task_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_task_queue.sv
// Per-PE task buffer: a DEPTH-entry FIFO per lane feeding an Edge PE through valid/ready,
// with each lane tracking issue/execute until the PE pulses done.
module edge_task_queue #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned PKT_W  = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PKT_W-1:0]  task_in_packet_0,
  input  logic [PKT_W-1:0]  task_in_packet_1,
  input  logic [PKT_W-1:0]  task_in_packet_2,
  input  logic [PKT_W-1:0]  task_in_packet_3,
  input  logic [NUM_PE-1:0] task_in_valid,
  input  logic [NUM_PE-1:0] pe_ready,
  input  logic [NUM_PE-1:0] pe_done,
  output logic [PKT_W-1:0]  pe_packet_0,
  output logic [PKT_W-1:0]  pe_packet_1,
  output logic [PKT_W-1:0]  pe_packet_2,
  output logic [PKT_W-1:0]  pe_packet_3,
  output logic [NUM_PE-1:0] pe_valid,
  output logic [NUM_PE-1:0] PE_IDLE,
  output logic [NUM_PE-1:0] queue_full,
  output logic              overflow_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StExec} lane_state_e;

  logic [NUM_PE-1:0][PKT_W-1:0] w_in_pkt;
  logic [NUM_PE-1:0][PKT_W-1:0] w_out_pkt;
  logic [NUM_PE-1:0]            w_ovf;
  logic                         r_ovf;

  // The packet ports are fixed at four lanes; NUM_PE is expected to be 4.
  assign w_in_pkt[0] = task_in_packet_0;
  assign w_in_pkt[1] = task_in_packet_1;
  assign w_in_pkt[2] = task_in_packet_2;
  assign w_in_pkt[3] = task_in_packet_3;
  assign pe_packet_0 = w_out_pkt[0];
  assign pe_packet_1 = w_out_pkt[1];
  assign pe_packet_2 = w_out_pkt[2];
  assign pe_packet_3 = w_out_pkt[3];

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    lane_state_e      r_state, w_state_d;
    logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
    logic [CntW-1:0]  r_count, w_count_d;
    logic [PKT_W-1:0] r_pkt, w_pkt_d;
    logic [PKT_W-1:0] r_mem [DEPTH];
    logic             w_full, w_pop, w_push;

    assign w_full   = (r_count == CntW'(DEPTH));
    assign w_pop    = (r_state == StIssue) && pe_ready[i];
    // A pop frees the slot in the same cycle, so a full lane can still accept.
    assign w_push   = task_in_valid[i] && (!w_full || w_pop);
    assign w_ovf[i] = task_in_valid[i] && w_full && !w_pop;

    always_comb begin
      w_state_d  = r_state;
      w_pkt_d    = r_pkt;
      w_wr_ptr_d = r_wr_ptr;
      w_rd_ptr_d = r_rd_ptr;
      w_count_d  = r_count;
      if (w_push) w_wr_ptr_d = r_wr_ptr + PtrW'(1);
      if (w_pop)  w_rd_ptr_d = r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        w_count_d = r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        w_count_d = r_count - CntW'(1);
      end
      unique case (r_state)
        StIdle: begin
          if (r_count != '0) begin
            w_state_d = StIssue;
            w_pkt_d   = r_mem[r_rd_ptr];
          end
        end
        StIssue: begin
          if (pe_ready[i]) w_state_d = StExec;
        end
        StExec: begin
          // Decision uses the pre-edge count: a same-cycle enqueue goes via IDLE.
          if (pe_done[i]) begin
            if (r_count != '0) begin
              w_state_d = StIssue;
              w_pkt_d   = r_mem[r_rd_ptr];
            end else begin
              w_state_d = StIdle;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state  <= StIdle;
        r_pkt    <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_state  <= w_state_d;
        r_pkt    <= w_pkt_d;
        r_wr_ptr <= w_wr_ptr_d;
        r_rd_ptr <= w_rd_ptr_d;
        r_count  <= w_count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= w_in_pkt[i];
    end

    assign w_out_pkt[i]  = r_pkt;
    assign pe_valid[i]   = (r_state == StIssue);
    assign PE_IDLE[i]    = (r_state == StIdle) && (r_count == '0);
    assign queue_full[i] = w_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (|w_ovf);
    end
  end

  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_edge_task_queue.sv
// Bench for edge_task_queue: directed scenarios plus random traffic scored against a
// queue-based per-lane model.
module tb_edge_task_queue;
  localparam int NP = 4;
  localparam int PW = 16;
  localparam int D  = 2;

  typedef logic [PW-1:0] pkt_t;

  logic          clk = 1'b0;
  logic          reset;
  pkt_t          tin [NP];
  logic [NP-1:0] tv, rdy, done;
  pkt_t          pout [NP];
  logic [NP-1:0] pv, idle, qf;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  // Model: per-lane task queue (head included while presented) plus a phase:
  // 0 waiting, 1 presenting, 2 PE busy.
  pkt_t mq [NP][$];
  int   mph [NP];
  pkt_t mpkt [NP];
  bit   movf;

  edge_task_queue #(.NUM_PE(NP), .PKT_W(PW), .DEPTH(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .task_in_packet_0 (tin[0]),
    .task_in_packet_1 (tin[1]),
    .task_in_packet_2 (tin[2]),
    .task_in_packet_3 (tin[3]),
    .task_in_valid    (tv),
    .pe_ready         (rdy),
    .pe_done          (done),
    .pe_packet_0      (pout[0]),
    .pe_packet_1      (pout[1]),
    .pe_packet_2      (pout[2]),
    .pe_packet_3      (pout[3]),
    .pe_valid         (pv),
    .PE_IDLE          (idle),
    .queue_full       (qf),
    .overflow_err     (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] m_valid();
    for (int i = 0; i < NP; i++) m_valid[i] = (mph[i] == 1);
  endfunction

  function automatic logic [NP-1:0] m_idle();
    for (int i = 0; i < NP; i++) m_idle[i] = (mph[i] == 0) && (mq[i].size() == 0);
  endfunction

  function automatic logic [NP-1:0] m_full();
    for (int i = 0; i < NP; i++) m_full[i] = (mq[i].size() == D);
  endfunction

  // Advance one clock edge, update the model from the inputs held across it, settle 1ns.
  task automatic step();
    bit pop, full;
    int n;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NP; i++) begin
        mq[i].delete();
        mph[i]  = 0;
        mpkt[i] = '0;
      end
      movf = 1'b0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        n    = mq[i].size();
        full = (n == D);
        pop  = (mph[i] == 1) && rdy[i];
        if (tv[i] && full && !pop) movf = 1'b1;
        case (mph[i])
          0: if (n > 0) begin mph[i] = 1; mpkt[i] = mq[i][0]; end
          1: if (rdy[i]) mph[i] = 2;
          default: if (done[i]) begin
            if (n > 0) begin mph[i] = 1; mpkt[i] = mq[i][0]; end
            else mph[i] = 0;
          end
        endcase
        if (pop) void'(mq[i].pop_front());
        if (tv[i] && (!full || pop)) mq[i].push_back(tin[i]);
      end
    end
    #1;
  endtask

  task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0] r, input logic [NP-1:0] d);
    tv = v; rdy = r; done = d;
  endtask

  task automatic apply_reset();
    drive('0, '0, '0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) step();
    checks++;
    if (idle !== 4'b1111) begin errors++; $display("FAIL reset_idle got %b want 1111", idle); end
    checks++;
    if (pv !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", pv); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++;
    if (qf !== 4'b0000) begin errors++; $display("FAIL reset_full got %b want 0000", qf); end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (pout[i] !== '0) begin errors++; $display("FAIL reset_pkt%0d got %h want 0", i, pout[i]); end
    end
  endtask

  task automatic test_single_issue();
    tin[0] = 16'h002A;
    drive(4'b0001, 4'b0001, 4'b0000);
    step();
    drive(4'b0000, 4'b0001, 4'b0000);
    checks++;
    if (pv[0] !== 1'b0 || idle[0] !== 1'b0) begin
      errors++; $display("FAIL single_t valid %b idle %b want 0 0", pv[0], idle[0]);
    end
    step();
    checks++;
    if (pv[0] !== 1'b1 || pout[0] !== 16'h002A) begin
      errors++; $display("FAIL single_issue valid %b pkt %h want 1 002a", pv[0], pout[0]);
    end
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (pv[0] !== 1'b0 || idle[0] !== 1'b0) begin
      errors++; $display("FAIL single_exec valid %b idle %b want 0 0", pv[0], idle[0]);
    end
    step();
    step();
    checks++;
    if (idle[0] !== 1'b0) begin errors++; $display("FAIL single_busy idle %b want 0", idle[0]); end
    drive(4'b0000, 4'b0000, 4'b0001);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (idle[0] !== 1'b1) begin errors++; $display("FAIL single_done idle %b want 1", idle[0]); end
  endtask

  task automatic test_overflow();
    tin[1] = 16'h0A11;
    drive(4'b0010, 4'b0000, 4'b0000);
    step();
    tin[1] = 16'h0B22;
    step();
    checks++;
    if (qf[1] !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", qf[1]); end
    tin[1] = 16'h0C33;
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    step();
    checks++;
    if (ovf !== 1'b1 || pv[1] !== 1'b1 || pout[1] !== 16'h0A11) begin
      errors++; $display("FAIL ovf_headA ovf %b valid %b pkt %h want 1 1 0a11", ovf, pv[1], pout[1]);
    end
    drive(4'b0000, 4'b0010, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0010);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (pv[1] !== 1'b1 || pout[1] !== 16'h0B22) begin
      errors++; $display("FAIL ovf_headB valid %b pkt %h want 1 0b22", pv[1], pout[1]);
    end
    drive(4'b0000, 4'b0010, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0010);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (idle[1] !== 1'b1 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_drained idle %b ovf %b want 1 1", idle[1], ovf);
    end
  endtask

  task automatic test_full_pop();
    apply_reset();
    tin[2] = 16'h1111;
    drive(4'b0100, 4'b0000, 4'b0000);
    step();
    tin[2] = 16'h2222;
    step();
    tin[2] = 16'h3333;
    drive(4'b0100, 4'b0100, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (ovf !== 1'b0 || qf[2] !== 1'b1) begin
      errors++; $display("FAIL fullpop ovf %b full %b want 0 1", ovf, qf[2]);
    end
    drive(4'b0000, 4'b0000, 4'b0100);
    step();
    checks++;
    if (pv[2] !== 1'b1 || pout[2] !== 16'h2222) begin
      errors++; $display("FAIL fullpop_second valid %b pkt %h want 1 2222", pv[2], pout[2]);
    end
    drive(4'b0000, 4'b0100, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0100);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (pv[2] !== 1'b1 || pout[2] !== 16'h3333) begin
      errors++; $display("FAIL fullpop_third valid %b pkt %h want 1 3333", pv[2], pout[2]);
    end
    drive(4'b0000, 4'b0100, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0100);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_all_lanes();
    pkt_t want [NP];
    apply_reset();
    for (int i = 0; i < NP; i++) begin
      want[i] = pkt_t'(16'h4000 + 16'h0101 * i);
      tin[i]  = want[i];
    end
    drive(4'b1111, 4'b0000, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    checks++;
    if (pv !== 4'b1111) begin errors++; $display("FAIL all_valid got %b want 1111", pv); end
    drive(4'b0000, 4'b1000, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    checks++;
    if (pv !== 4'b0111 || idle !== 4'b0000) begin
      errors++; $display("FAIL all_lane3 valid %b idle %b want 0111 0000", pv, idle);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pout[i] !== want[i]) begin
        errors++; $display("FAIL all_pkt%0d got %h want %h", i, pout[i], want[i]);
      end
    end
    drive(4'b0000, 4'b0111, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b1111);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (idle !== 4'b1111) begin errors++; $display("FAIL all_drain idle %b want 1111", idle); end
  endtask

  task automatic test_reset_mid();
    tin[0] = 16'h5A5A;
    drive(4'b0001, 4'b0000, 4'b0000);
    step();
    tin[0] = 16'h6B6B;
    step();
    drive(4'b0000, 4'b0001, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (pv[0] !== 1'b0 || qf[0] !== 1'b0 || idle[0] !== 1'b0) begin
      errors++; $display("FAIL mid_exec valid %b full %b idle %b want 0 0 0", pv[0], qf[0], idle[0]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (pv !== 4'b0000 || idle !== 4'b1111 || qf !== 4'b0000 || ovf !== 1'b0 || pout[0] !== '0) begin
      errors++;
      $display("FAIL mid_reset valid %b idle %b full %b ovf %b pkt %h want 0000 1111 0000 0 0000",
               pv, idle, qf, ovf, pout[0]);
    end
    drive(4'b0000, 4'b0000, 4'b0001);
    step();
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    checks++;
    if (pv !== 4'b0000 || idle !== 4'b1111) begin
      errors++; $display("FAIL mid_done valid %b idle %b want 0000 1111", pv, idle);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) tin[i] = pkt_t'($urandom);
      drive(NP'($urandom), NP'($urandom), NP'($urandom));
      // Occasionally stop traffic so lanes drain and wrap pointers repeatedly.
      if (c % 50 > 40) tv = '0;
      step();
      checks++;
      if (pv !== m_valid()) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, pv, m_valid());
      end
      checks++;
      if (idle !== m_idle()) begin
        errors++; $display("FAIL rnd_idle cyc %0d got %b want %b", c, idle, m_idle());
      end
      checks++;
      if (qf !== m_full()) begin
        errors++; $display("FAIL rnd_full cyc %0d got %b want %b", c, qf, m_full());
      end
      checks++;
      if (ovf !== movf) begin
        errors++; $display("FAIL rnd_ovf cyc %0d got %b want %b", c, ovf, movf);
      end
      for (int i = 0; i < NP; i++) begin
        if (mph[i] == 1) begin
          checks++;
          if (pout[i] !== mpkt[i]) begin
            errors++; $display("FAIL rnd_pkt%0d cyc %0d got %h want %h", i, c, pout[i], mpkt[i]);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NP; i++) tin[i] = '0;
    tv = '0; rdy = '0; done = '0;
    test_reset();
    test_single_issue();
    test_overflow();
    test_full_pop();
    test_all_lanes();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
